// File: rtl/usrt_pkg.sv
// ----------------------------------------------------------------------------
// usrt_pkg
// Types and constants shared by the USRT receiver and the future transmitter.
//   USRT_DATA_BITS  : default data bits per frame
//   usrt_rx_state_t : receiver framing FSM states
// ----------------------------------------------------------------------------
package usrt_pkg;

    localparam int unsigned USRT_DATA_BITS = 8;

    // StParity is only entered when the parity option is built in.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } usrt_rx_state_t;

endpackage

// File: rtl/usrt_rx_if.sv
// ----------------------------------------------------------------------------
// usrt_rx_if
// Received-word handshake between usrt_rx (master) and its consumer (slave).
//   rx_data    : received word, stable while rx_valid
//   rx_par_err : parity error flag accompanying rx_data
//   rx_valid   : rx_data holds an unconsumed word
//   rx_ready   : consumer accepts the word (transfer when valid && ready)
// ----------------------------------------------------------------------------
interface usrt_rx_if
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_BITS = USRT_DATA_BITS
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_par_err;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_par_err,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_par_err,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/usrt_rx_buf.sv
// ----------------------------------------------------------------------------
// usrt_rx_buf
// One-entry output register with valid/ready handshake and overrun detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : a completed frame is offered this cycle
//   i_data     : word of the completed frame
//   i_par      : parity error flag of the completed frame
//   i_ready    : consumer ready
//   o_data     : held word
//   o_par      : held parity error flag
//   o_valid    : held word not yet consumed
//   o_overrun  : one-cycle pulse, an offered frame was dropped
// ----------------------------------------------------------------------------
module usrt_rx_buf #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_par,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_par,
    output logic                 o_valid,
    output logic                 o_overrun
);

    logic [DATA_BITS-1:0] r_data;
    logic                 r_par;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 w_drain;

    assign w_drain = r_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_par     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // A drain in the same cycle frees the slot for the new word.
                if (!r_valid || w_drain) begin
                    r_data  <= i_data;
                    r_par   <= i_par;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_par     = r_par;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/usrt_rx.sv
// ----------------------------------------------------------------------------
// usrt_rx
// Serial-to-parallel USRT receiver. Samples usrt_data on usrt_pedge strobes,
// frames start / data (LSB first) / [parity] / stop, and hands words to a
// one-entry output register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   usrt_pedge  : one-cycle strobe marking a USRT clock rising edge
//   usrt_data   : serial data, synchronous to clk and aligned to usrt_pedge
//   rx          : usrt_rx_if.master word handshake (data, par_err, valid, ready)
//   err_frame   : one-cycle pulse, stop bit sampled as 0
//   err_overrun : one-cycle pulse, a completed frame was dropped
//   busy        : receiver is inside a frame
// Build option: USRT_RX_PARITY_EN adds an even parity bit after the data bits.
// ----------------------------------------------------------------------------
module usrt_rx
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_BITS = USRT_DATA_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        usrt_pedge,
    input  logic        usrt_data,
    usrt_rx_if.master   rx,
    output logic        err_frame,
    output logic        err_overrun,
    output logic        busy
);

    localparam int unsigned    CntW    = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

    usrt_rx_state_t       r_state;
    logic [CntW-1:0]      r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_busy;
    logic                 r_err_frame;
`ifdef USRT_RX_PARITY_EN
    logic                 r_par_bit;
`endif

    logic                 w_frame_done;
    logic                 w_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_err_frame <= 1'b0;
`ifdef USRT_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_err_frame <= 1'b0;
            if (usrt_pedge) begin
                case (r_state)
                    StIdle: begin
                        if (!usrt_data) begin
                            r_cnt   <= '0;
                            r_state <= StData;
                            r_busy  <= 1'b1;
                        end
                    end
                    StData: begin
                        // Shift right from the MSB so the first bit lands at bit 0.
                        r_shift <= {usrt_data, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LastBit) begin
`ifdef USRT_RX_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StStop;
`endif
                        end
                    end
`ifdef USRT_RX_PARITY_EN
                    StParity: begin
                        r_par_bit <= usrt_data;
                        r_state   <= StStop;
                    end
`endif
                    StStop: begin
                        r_state     <= StIdle;
                        r_busy      <= 1'b0;
                        r_err_frame <= !usrt_data;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_frame_done = usrt_pedge && (r_state == StStop) && usrt_data;

`ifdef USRT_RX_PARITY_EN
    // Even parity: data plus parity bit must XOR to 0.
    assign w_par_err = ^{r_shift, r_par_bit};
`else
    assign w_par_err = 1'b0;
`endif

    usrt_rx_buf #(
        .DATA_BITS (DATA_BITS)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_frame_done),
        .i_data    (r_shift),
        .i_par     (w_par_err),
        .i_ready   (rx.rx_ready),
        .o_data    (rx.rx_data),
        .o_par     (rx.rx_par_err),
        .o_valid   (rx.rx_valid),
        .o_overrun (err_overrun)
    );

    assign err_frame = r_err_frame;
    assign busy      = r_busy;

endmodule

// File: doc/usrt_rx.md
# usrt_rx

Serial-to-parallel receiver for the synchronous USRT link, directly downstream of `usrt_posedge`. It samples the serial data line on each single-cycle `usrt_pedge` strobe produced by that block and frames bits as start / data / [parity] / stop. Received words go to a one-entry output register with a valid/ready handshake, plus frame, parity and overrun error reporting. The whole block runs in the system `clk` domain.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first; legal range 5..9.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `usrt_pedge` input 1: one-`clk`-cycle strobe marking a USRT clock rising edge, from `usrt_posedge`.
- `usrt_data` input 1: serial data. It is already synchronized to `clk` and aligned to `usrt_pedge` upstream.
- `rx_data` output `DATA_BITS`: received word. Stable while `rx_valid`=1.
- `rx_par_err` output 1: parity error flag accompanying `rx_data`. Tied 0 without the macro.
- `rx_valid` output 1: `rx_data` holds an unconsumed word.
- `rx_ready` input 1: consumer accepts the word; the transfer occurs when `rx_valid && rx_ready` at a clock edge.
- `err_frame` output 1: one-cycle pulse, stop bit sampled as 0.
- `err_overrun` output 1: one-cycle pulse, a completed frame was dropped.
- `busy` output 1: high in any state except IDLE.

## Operation
- `usrt_data` is sampled only in cycles where `usrt_pedge`=1. No state advances in other cycles.
- FSM states: IDLE, DATA, PARITY (macro only), STOP.
  - IDLE: a strobe with `usrt_data`=0 is the start bit. Clear the bit counter and go to DATA. A strobe with `usrt_data`=1 keeps the FSM in IDLE.
  - DATA: each strobe shifts `usrt_data` into the shift register MSB, shifting right, so the first bit ends up at bit 0. After `DATA_BITS` strobes the FSM goes to PARITY, or to STOP without the macro.
  - PARITY: one strobe. Store the sampled bit, then go to STOP.
  - STOP: one strobe, then always return to IDLE.
    - Sample = 1: the frame is complete and is offered to the output register.
    - Sample = 0: pulse `err_frame`, discard the word, leave the output register unchanged.
- Bit counter width is `$clog2(DATA_BITS+1)`. The counter never wraps past `DATA_BITS`.
- Output register loading for a completed frame:
  - Register empty, or being drained this cycle (`rx_valid && rx_ready`): load `rx_data` and `rx_par_err`, and `rx_valid` stays or goes 1.
  - Register full and not drained this cycle: drop the new frame, pulse `err_overrun`, keep the old word.
- A handshake with no new frame clears `rx_valid`.
- Back-to-back frames are legal: a start bit is accepted on the strobe immediately after the stop-bit strobe.

## Timing
- Reset values: FSM=IDLE, counter=0, shift register=0, `rx_data`=0, `rx_par_err`=0, `rx_valid`=0, `err_frame`=0, `err_overrun`=0, `busy`=0.
- Assertion of `rst_n` mid-frame aborts the frame immediately. The partial word is never delivered.
- Latency: `rx_valid`, `err_frame` and `err_overrun` are registered. They change on the `clk` edge ending the cycle in which the stop-bit strobe is high.
- The error pulses last exactly one `clk` cycle.
- `rx_ready` has no effect while `rx_valid`=0.
- `busy` rises on the edge after the start-bit strobe and falls on the edge after the stop-bit strobe.

## Configuration
- `USRT_RX_PARITY_EN` defined:
  - The PARITY state is present; the frame is start + `DATA_BITS` + parity + stop.
  - Parity is even over data plus parity bit.
  - `rx_par_err` = 1 when the XOR of the data and parity bits is 1.
  - A word with a parity error is still delivered.
- Undefined:
  - No PARITY state; the frame is start + `DATA_BITS` + stop.
  - `rx_par_err` is constant 0.

## Structure
- Shared package `usrt_pkg` holds:
  - the FSM state enum `usrt_rx_state_t`;
  - the default data width constant `USRT_DATA_BITS`=8, shared with the future transmitter.
- One sub-module, `usrt_rx_buf`: the one-entry output register with valid/ready, load and overrun logic.
- The FSM, shift register and counter stay in `usrt_rx`.

## Test plan
- Frame 0 / 0xA5 LSB first / [even parity 0] / 1, with `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` high for one cycle, no error pulses.
- Stop bit driven 0 on frame 0x3C → single `err_frame` pulse, `rx_valid` stays 0, FSM returns to IDLE.
- Two frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11, one `err_overrun` pulse. Raising `rx_ready` then drains 0x11.
- `rx_ready` high in the same cycle the second frame 0x22 completes → 0x11 consumed, 0x22 loaded, `rx_valid` stays 1, no overrun.
- `rst_n` pulsed low after 4 data bits, then a full 0x5A frame → only 0x5A is delivered; all outputs are 0 during reset.
- With `USRT_RX_PARITY_EN`, 0x07 with parity bit 0 → `rx_data`=0x07 with `rx_par_err`=1. Repeat with parity bit 1 → `rx_par_err`=0.
